// File: rtl/pixel_block_packer.sv
`default_nettype none
// ============================================================================
// pixel_block_packer : packs an R,G,B byte stream into PIXELS-pixel blocks,
// holds one pending block and hands it out on a rising ram_ask.   Rev 1.0
// ============================================================================
module pixel_block_packer #(
   parameter int PIXELS  = 256,
   parameter int PIXEL_W = 24
) (
   input  logic                        clk125,
   input  logic                        reset,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   input  logic                        rx_sof,
   input  logic                        ram_ask,
   output logic [PIXELS*PIXEL_W-1:0]   pixel_data,
   output logic                        new_frame,
   output logic [7:0]                  debug
);

   localparam int               CNT_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);
   localparam logic [1:0]       PH_R     = 2'd0;
   localparam logic [1:0]       PH_G     = 2'd1;
   localparam logic [1:0]       PH_B     = 2'd2;

   typedef logic [PIXELS-1:0][PIXEL_W-1:0] block_t;

   logic [1:0]       phase_q,        phase_d;
   logic [CNT_W-1:0] pix_cnt_q,      pix_cnt_d;
   logic [7:0]       r_q,            r_d;
   logic [7:0]       g_q,            g_d;
   block_t           asm_q,          asm_d;
   block_t           pending_q,      pending_d;
   block_t           pixel_q,        pixel_d;
   logic             pending_full_q, pending_full_d;
   logic             pending_tag_q,  pending_tag_d;
   logic             frame_tag_q,    frame_tag_d;
   logic             new_frame_q,    new_frame_d;
   logic             overrun_q,      overrun_d;
   logic             underrun_q,     underrun_d;
   logic             sof_seen_q,     sof_seen_d;
   logic             ram_ask_d_q;

   logic   w_ask_edge;
   logic   w_pix_done;
   logic   w_complete;
   block_t w_block;

   assign w_ask_edge = ram_ask & ~ram_ask_d_q;
   assign w_pix_done = rx_valid & ~rx_sof & (phase_q == PH_B);
   assign w_complete = w_pix_done & (pix_cnt_q == LAST_PIX);

   always_comb begin
      phase_d        = phase_q;
      pix_cnt_d      = pix_cnt_q;
      r_d            = r_q;
      g_d            = g_q;
      pending_d      = pending_q;
      pixel_d        = pixel_q;
      pending_full_d = pending_full_q;
      pending_tag_d  = pending_tag_q;
      frame_tag_d    = frame_tag_q;
      new_frame_d    = 1'b0;
      overrun_d      = overrun_q;
      underrun_d     = underrun_q;
      sof_seen_d     = sof_seen_q;

      // w_block is the assembly register including the pixel finishing this cycle
      w_block = asm_q;
      if (w_pix_done) begin
         w_block[pix_cnt_q] = PIXEL_W'({r_q, g_q, rx_data});
      end
      asm_d = w_block;

      if (rx_valid) begin
         if (rx_sof) begin
            r_d         = rx_data;
            phase_d     = PH_G;
            pix_cnt_d   = '0;
            frame_tag_d = 1'b1;
            sof_seen_d  = 1'b1;
         end else begin
            case (phase_q)
               PH_G: begin
                  g_d     = rx_data;
                  phase_d = PH_B;
               end
               PH_B: begin
                  phase_d   = PH_R;
                  pix_cnt_d = w_complete ? '0 : pix_cnt_q + 1'b1;
               end
               default: begin
                  r_d     = rx_data;
                  phase_d = PH_G;
               end
            endcase
         end
      end

      if (w_ask_edge) begin
         if (pending_full_q) begin
            pixel_d        = pending_q;
            new_frame_d    = pending_tag_q;
            pending_full_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
      end

      // A completing block may refill pending only if it is empty or being drained now
      if (w_complete) begin
         if (!pending_full_q || w_ask_edge) begin
            pending_d      = w_block;
            pending_tag_d  = frame_tag_q;
            pending_full_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
         frame_tag_d = 1'b0;
      end
   end

   always_ff @(posedge clk125) begin
      if (reset) begin
         phase_q        <= PH_R;
         pix_cnt_q      <= '0;
         r_q            <= '0;
         g_q            <= '0;
         asm_q          <= '0;
         pending_q      <= '0;
         pixel_q        <= '0;
         pending_full_q <= 1'b0;
         pending_tag_q  <= 1'b0;
         frame_tag_q    <= 1'b0;
         new_frame_q    <= 1'b0;
         overrun_q      <= 1'b0;
         underrun_q     <= 1'b0;
         sof_seen_q     <= 1'b0;
         ram_ask_d_q    <= 1'b0;
      end else begin
         phase_q        <= phase_d;
         pix_cnt_q      <= pix_cnt_d;
         r_q            <= r_d;
         g_q            <= g_d;
         asm_q          <= asm_d;
         pending_q      <= pending_d;
         pixel_q        <= pixel_d;
         pending_full_q <= pending_full_d;
         pending_tag_q  <= pending_tag_d;
         frame_tag_q    <= frame_tag_d;
         new_frame_q    <= new_frame_d;
         overrun_q      <= overrun_d;
         underrun_q     <= underrun_d;
         sof_seen_q     <= sof_seen_d;
         ram_ask_d_q    <= ram_ask;
      end
   end

   assign pixel_data = pixel_q;
   assign new_frame  = new_frame_q;
   assign debug      = {overrun_q, underrun_q, pending_full_q, sof_seen_q, phase_q, 2'b00};

endmodule
`default_nettype wire
